pixel_frame_controller: RTL



---
 rtl/pixel_frame_controller.sv | 103 ++++++++++
 1 files changed

// File: rtl/pixel_frame_controller.sv
// Frame sequencer for the pixel array: erase -> expose -> convert -> read1 -> read2,
// with a ramp-synchronous conversion code and a start/busy/done handshake.
module pixel_frame_controller #(
  parameter int unsigned ERASE_CYCLES   = 5,
  parameter int unsigned EXPOSE_CYCLES  = 255,
  parameter int unsigned CONVERT_CYCLES = 255,
  parameter int unsigned READ_CYCLES    = 5,
  parameter int unsigned COUNT_W        = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  output logic               erase,
  output logic               expose,
  output logic               convert,
  output logic               read1,
  output logic               read2,
  output logic [COUNT_W-1:0] conv_code,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ1,
    READ2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phase_last;
  logic             phase_end;

  always_comb begin
    phase_last = '0;
    case (state)
      ERASE:   phase_last = CNT_W'(ERASE_CYCLES - 1);
      EXPOSE:  phase_last = CNT_W'(EXPOSE_CYCLES - 1);
      CONVERT: phase_last = CNT_W'(CONVERT_CYCLES - 1);
      READ1:   phase_last = CNT_W'(READ_CYCLES - 1);
      READ2:   phase_last = CNT_W'(READ_CYCLES - 1);
      default: phase_last = '0;
    endcase
  end

  assign phase_end = (cnt == phase_last);

  // abort outranks both start (in IDLE) and every phase transition
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (start && !abort) state_nxt = ERASE;
    end else if (abort) begin
      state_nxt = IDLE;
    end else if (phase_end) begin
      case (state)
        ERASE:   state_nxt = EXPOSE;
        EXPOSE:  state_nxt = CONVERT;
        CONVERT: state_nxt = READ1;
        READ1:   state_nxt = READ2;
        READ2:   state_nxt = continuous ? ERASE : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read1      <= 1'b0;
      read2      <= 1'b0;
      conv_code  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + CNT_W'(1);
      erase      <= (state_nxt == ERASE);
      expose     <= (state_nxt == EXPOSE);
      convert    <= (state_nxt == CONVERT);
      read1      <= (state_nxt == READ1);
      read2      <= (state_nxt == READ2);
      busy       <= (state_nxt != IDLE);
      frame_done <= (state == READ2) && phase_end && !abort;
      if (state == CONVERT && state_nxt == CONVERT) conv_code <= conv_code + COUNT_W'(1);
      else                                          conv_code <= '0;
    end
  end

endmodule
